// File: rtl/bm_search_sequencer.sv
// rtl/bm_search_sequencer.sv - candidate offset sequencer for stereo block matching; optional BM_SEQ_PERF_EN perf counters
module bm_search_sequencer #(
  parameter int num_h_offsets   = 48,
  parameter int num_v_offsets   = 4,
  parameter int max_outstanding = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [15:0] blk_index,
  output logic        cand_valid,
  input  logic        cand_ready,
  output logic [15:0] cand_coords,
  output logic [15:0] cand_blk_index,
  output logic        cand_first,
  output logic        cand_last,
  input  logic        res_valid,
  input  logic        flush,
  output logic        busy,
  output logic [3:0]  outstanding,
  output logic        res_underflow
`ifdef BM_SEQ_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_blocks_done
`endif
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [7:0] H_LAST  = 8'(num_h_offsets - 1);
  localparam logic [7:0] V_LAST  = 8'(num_v_offsets - 1);
  localparam logic [3:0] MAX_OUT = 4'(max_outstanding);

  state_t      state_q, state_d;
  logic [7:0]  h_cnt_q, h_cnt_d;
  logic [7:0]  v_cnt_q, v_cnt_d;
  logic [15:0] blk_idx_q, blk_idx_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        underflow_q, underflow_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        last_hs;

  assign blk_ready      = (state_q == IDLE) && (outstanding_q < MAX_OUT) && !flush;
  assign cand_valid     = (state_q == SCAN);
  assign cand_coords    = {v_cnt_q, h_cnt_q};
  assign cand_blk_index = blk_idx_q;
  assign cand_first     = first_q;
  assign cand_last      = last_q;
  assign busy           = (state_q == SCAN) || (outstanding_q != 4'd0);
  assign outstanding    = outstanding_q;
  assign res_underflow  = underflow_q;

  // Next-state: scan walk (v ascending, h descending), in-flight accounting, flush abort
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    blk_idx_d     = blk_idx_q;
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    last_hs       = (state_q == SCAN) && cand_ready && last_q;

    if (flush) begin
      state_d       = IDLE;
      outstanding_d = 4'd0;
    end else begin
      if (state_q == IDLE) begin
        if (blk_valid && blk_ready) begin
          state_d   = SCAN;
          blk_idx_d = blk_index;
          v_cnt_d   = 8'd0;
          h_cnt_d   = H_LAST;
        end
      end else if (cand_ready) begin
        if (last_q) begin
          state_d = IDLE;
        end else if (h_cnt_q == 8'd0) begin
          h_cnt_d = H_LAST;
          v_cnt_d = v_cnt_q + 8'd1;
        end else begin
          h_cnt_d = h_cnt_q - 8'd1;
        end
      end

      // A finishing block and a returning result in the same cycle cancel out
      if (last_hs && !res_valid) begin
        outstanding_d = outstanding_q + 4'd1;
      end else if (res_valid && !last_hs) begin
        if (outstanding_q == 4'd0) begin
          underflow_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q - 4'd1;
        end
      end
    end

    first_d = (state_d == SCAN) && (v_cnt_d == 8'd0) && (h_cnt_d == H_LAST);
    last_d  = (state_d == SCAN) && (v_cnt_d == V_LAST) && (h_cnt_d == 8'd0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      h_cnt_q       <= 8'd0;
      v_cnt_q       <= 8'd0;
      blk_idx_q     <= 16'd0;
      outstanding_q <= 4'd0;
      underflow_q   <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      blk_idx_q     <= blk_idx_d;
      outstanding_q <= outstanding_d;
      underflow_q   <= underflow_d;
      first_q       <= first_d;
      last_q        <= last_d;
    end
  end

`ifdef BM_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] done_q, done_d;

  assign perf_stall_cycles = stall_q;
  assign perf_blocks_done  = done_q;

  // Free-running wrap counters; flush deliberately leaves them alone
  always_comb begin
    stall_d = stall_q;
    done_d  = done_q;
    if (cand_valid && !cand_ready) stall_d = stall_q + 32'd1;
    if (res_valid) done_d = done_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 32'd0;
      done_q  <= 32'd0;
    end else begin
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end
`endif

endmodule

// File: doc/bm_search_sequencer.md
# bm_search_sequencer

Generates the candidate offset stream for the stereo block-matching datapath. For each accepted reference block it walks every search offset in a fixed order and emits one candidate per handshake to the XOR/popcount sum stage. It also throttles new blocks against results returned by the minimum-distance finder. It sits between the block fetch logic and the sum/min-distance pipeline.

## Interface
Parameters:
- num_h_offsets, 48: horizontal offsets per block, range 1..255.
- num_v_offsets, 4: vertical offsets per block, range 1..255.
- max_outstanding, 4: blocks allowed in flight in the downstream pipeline, range 1..15.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- blk_valid  in  1  block descriptor offered.
- blk_ready  out  1  descriptor accepted when both blk_valid and blk_ready are high.
- blk_index  in  16  block index, captured on accept.
- cand_valid  out  1  candidate offered to the sum stage.
- cand_ready  in  1  sum stage accepts the candidate.
- cand_coords  out  16  {v[7:0], h[7:0]} offset of the current candidate.
- cand_blk_index  out  16  captured blk_index of the current block.
- cand_first  out  1  first candidate of the block.
- cand_last  out  1  last candidate of the block.
- res_valid  in  1  one-cycle completion pulse from the min-distance finder, one per block.
- flush  in  1  synchronous abort.
- busy  out  1  high when state is SCAN or outstanding is nonzero.
- outstanding  out  4  number of blocks in flight.
- res_underflow  out  1  sticky error flag.

## Operation
- States are IDLE and SCAN.
- blk_ready = (state==IDLE) && (outstanding < max_outstanding) && !flush.
- IDLE to SCAN on accept:
  - capture blk_index;
  - v_cnt=0, h_cnt=num_h_offsets-1.
- Scan order:
  - outer loop v ascending, 0..num_v_offsets-1;
  - inner loop h descending, num_h_offsets-1..0.
  - The final candidate is therefore (v=num_v_offsets-1, h=0). This matches the last-coordinate detection in the min-distance finder.
- In SCAN, cand_valid is high.
  - On each handshake, advance: h_cnt decrements.
  - When h_cnt is 0 and the handshake occurs, h_cnt reloads to num_h_offsets-1 and v_cnt increments.
- Candidate flags:
  - cand_first = (v_cnt==0 && h_cnt==num_h_offsets-1).
  - cand_last = (v_cnt==num_v_offsets-1 && h_cnt==0).
- A handshake with cand_last high returns the block to IDLE and increments outstanding.
- A res_valid pulse decrements outstanding.
  - If a last handshake and res_valid occur in the same cycle, outstanding is unchanged.
  - res_valid while outstanding==0 (and no simultaneous increment): outstanding stays 0 and res_underflow sets. The flag is cleared only by reset.
- flush: next state is IDLE, outstanding is cleared to 0, any partial scan is discarded, and cand_valid drops on the next cycle. flush has priority over all other events in the same cycle.
- num_h_offsets=1: every candidate moves v. num_v_offsets=1 and num_h_offsets=1: a single candidate that has both cand_first and cand_last high.

## Timing
- Reset values:
  - state IDLE;
  - cand_valid, cand_first, cand_last, busy, res_underflow all 0;
  - cand_coords and cand_blk_index 0;
  - outstanding 0;
  - blk_ready 1 after reset deasserts, provided flush is low.
- Accept in cycle N: cand_valid high in cycle N+1 with coords {0, num_h_offsets-1}.
- Stalls: while cand_valid && !cand_ready, all cand_* outputs are held stable.
- Throughput:
  - one candidate per cycle with cand_ready tied high;
  - one IDLE bubble cycle between blocks;
  - per-block cost is num_v_offsets*num_h_offsets + 1 cycles.
- Outputs are registered. blk_ready is combinational from registered state plus flush.
- Asserting reset mid-scan forces the reset values immediately.

## Configuration
- BM_SEQ_PERF_EN defined:
  - adds output perf_stall_cycles[31:0], which counts cycles with cand_valid && !cand_ready;
  - adds output perf_blocks_done[31:0], which counts res_valid pulses;
  - both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Defaults, cand_ready=1, one block with blk_index=0x0123:
  - 192 candidates in cycles N+1..N+192;
  - first {0,47} with cand_first, second {0,46}, 49th {1,47}, last {3,0} with cand_last;
  - outstanding becomes 1 and busy stays 1 until res_valid.
- cand_ready toggled by a random 50% pattern:
  - coords are stable during stalls and no offset is skipped or repeated;
  - with BM_SEQ_PERF_EN, perf_stall_cycles equals the number of stall cycles.
- Offer 6 blocks with max_outstanding=4 and no res_valid:
  - after 4 blocks, blk_ready stays 0;
  - one res_valid re-enables blk_ready the next cycle.
- Issue res_valid in the same cycle as the cand_last handshake: outstanding is unchanged.
- Issue res_valid with outstanding=0: res_underflow=1 persists and outstanding stays 0.
- Assert flush at candidate 50:
  - cand_valid=0 next cycle and outstanding=0;
  - a new block restarts at {0,47}.
- Assert reset mid-scan: all outputs at reset values asynchronously.
